// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write/read side logic:
// data width, arbiter state encoding and a circular first-set picker.
package fifo_pkg;

    localparam int FIFO_DW = 16;

    // Widest request vector the picker handles (N_REQ is at most 8).
    localparam int RR_MAX = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Returns {any, index}: the first set bit of valid[n-1:0], searching
    // upwards from ptr and wrapping n-1 -> 0. ptr must be below n.
    function automatic logic [3:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input logic [2:0]        ptr,
        input logic [3:0]        n
    );
        logic       found;
        logic [2:0] pick;
        logic [3:0] pos;
        found = 1'b0;
        pick  = 3'd0;
        for (int k = 0; k < RR_MAX; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= n) begin
                pos = pos - n;
            end
            if (!found && (4'(k) < n) && valid[pos[2:0]]) begin
                found = 1'b1;
                pick  = pos[2:0];
            end
        end
        return {found, pick};
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_priority_pick: combinational circular priority encoder. Given a
// valid vector and a start pointer it reports the first valid index at
// or after the pointer (wrapping) and whether any input is valid.
module rr_priority_pick
    import fifo_pkg::*;
#(
    parameter int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [RR_MAX-1:0] valid_ext;
    logic [2:0]        ptr_ext;
    logic [3:0]        pick;
    logic              unused_pick;

    // Widen to the picker's fixed width and run the circular search.
    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = valid;
        ptr_ext            = '0;
        ptr_ext[IW-1:0]    = ptr;
        pick               = rr_pick(valid_ext, ptr_ext, 4'(N));
    end

    assign any = pick[3];
    assign idx = pick[IW-1:0];

    // Upper index bits are always zero for small N.
    assign unused_pick = ^pick;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async FIFO write port
// between N_REQ valid/ready producers. A grant lasts up to MAX_BURST words
// or until the grantee drops valid; wfull stalls the burst in place.
// Optional feature macro: WR_ARB_PARITY_FILTER_EN -- transfers of
// even-parity words are acknowledged but not written to the FIFO.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = FIFO_DW,
    parameter int MAX_BURST = 4,
    localparam int GW       = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]  req_ready,
    input  logic              wfull,
    output logic              winc,
    output logic [DW-1:0]     wdata,
    output logic [GW-1:0]     grant_id,
    output logic              busy
);

    localparam logic [0:0] S_IDLE  = ARB_IDLE;
    localparam logic [0:0] S_BURST = ARB_BURST;

    logic [0:0]    state_q,  state_d;
    logic [GW-1:0] grant_q,  grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]    beat_q,   beat_d;

    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic          grant_valid;
    logic          xfer;
    logic [3:0]    beat_inc;
    logic          last_beat;
    logic [GW-1:0] rr_next;

    rr_priority_pick #(
        .N (N_REQ)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign grant_valid = req_valid[grant_q];
    assign xfer        = (state_q == S_BURST) && grant_valid && !wfull;
    assign beat_inc    = beat_q + 4'd1;
    assign last_beat   = (beat_inc == 4'(MAX_BURST));
    assign rr_next     = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    // The granted producer's slice is always presented on the write bus.
    assign wdata    = req_data[grant_q*DW +: DW];
    assign grant_id = grant_q;
    assign busy     = (state_q == S_BURST);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = xfer && (grant_q == GW'(gi));
    end

`ifdef WR_ARB_PARITY_FILTER_EN
    // Even-parity words are consumed from the producer but never written.
    assign winc = xfer && (^wdata);
`else
    assign winc = xfer;
`endif

    // Next-state: grant in IDLE, count beats and close bursts in BURST.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        case (state_q)
            S_IDLE: begin
                if (pick_any && !wfull) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end
            default: begin
                if (!grant_valid) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = rr_next;
                end else if (xfer) begin
                    beat_d = beat_inc;
                    if (last_beat) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = rr_next;
                    end
                end
            end
        endcase
    end

    // Arbiter state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

endmodule
